mult_div: RTL and testbench

Iterative signed multiply/divide unit answering the control unit's `MULT_on`/`DIV_on` requests in the multicycle MIPS datapath. Accepts a one-cycle start pulse with operands from the A/B registers. Runs a 32-step radix-2 Booth multiply or restoring divide. Returns the 64-bit result to the Hi/Lo path with a one-cycle `done` pulse, and raises `dzero` on division by zero so the control unit can take the exception.

---
 rtl/mdu_pkg.sv | 14 +
 rtl/addsub33.sv | 12 +
 rtl/mult_div.sv | 175 +++++++++++++++++
 tb/tb_mult_div.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Purely declarative: no latency, no flow control.
package mdu_pkg;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/addsub33.sv
// Combinational adder/subtractor shared by the Booth and restoring steps.
// Zero latency; no flow control.
module addsub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);
    assign y = sub ? (a - b) : (a + b);
endmodule

// File: rtl/mult_div.sv
// Signed radix-2 Booth multiply / restoring divide, one add/sub per cycle; done in cycle 33 (mult), 34 (div), 1 (div by 0).
// No backpressure: start pulses outside IDLE are dropped, results hold until the next completion.
module mult_div
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MULT_on,
    input  logic             DIV_on,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic             busy,
    output logic             done,
    output logic             dzero
);
    localparam int AW = WIDTH + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [AW-1:0]      m_q, m_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dzero_q, dzero_d;

    logic [AW-1:0]      add_a, add_b, add_y, r_shift, booth_sum;
    logic               add_sub;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               last_step;

    assign a_mag     = A_in[WIDTH-1] ? -A_in : A_in;
    assign b_mag     = B_in[WIDTH-1] ? -B_in : B_in;
    assign r_shift   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign last_step = (cnt_q == CNT_W'(ITER_COUNT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dzero_q  <= dzero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (DIV_on)       state_d = (B_in == '0) ? DONE : DIV;
                else if (MULT_on) state_d = MULT;
            end
            MULT:    if (last_step) state_d = DONE;
            DIV:     if (last_step) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Divide uses the adder for the trial subtract; multiply picks add/sub from the Booth pair.
    always_comb begin
        add_a   = acc_q;
        add_b   = m_q;
        add_sub = 1'b0;
        if (state_q == DIV) begin
            add_a   = r_shift;
            add_sub = 1'b1;
        end else if ({q_q[0], qm1_q} == 2'b10) begin
            add_sub = 1'b1;
        end
    end

    addsub33 #(.W(AW)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .y   (add_y)
    );

    assign booth_sum = (q_q[0] ^ qm1_q) ? add_y : acc_q;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dzero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (DIV_on) begin
                    if (B_in != '0) begin
                        acc_d    = '0;
                        q_d      = a_mag;
                        m_d      = {1'b0, b_mag};
                        sign_a_d = A_in[WIDTH-1];
                        sign_b_d = B_in[WIDTH-1];
                    end else begin
                        dzero_d = 1'b1;
                    end
                end else if (MULT_on) begin
                    acc_d = '0;
                    q_d   = B_in;
                    qm1_d = 1'b0;
                    m_d   = {A_in[WIDTH-1], A_in};
                end
            end
            MULT: begin
                acc_d = {booth_sum[AW-1], booth_sum[AW-1:1]};
                q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hi_d = acc_d[WIDTH-1:0];
                    lo_d = q_d;
                end
            end
            DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (add_y[AW-1]) begin
                    acc_d = r_shift;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = add_y;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end
            end
            FIX: begin
                lo_d = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
                hi_d = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        dzero  = dzero_q;
        Hi_out = hi_q;
        Lo_out = lo_q;
    end
endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: signed products, quotients, divide-by-zero, ignored starts, mid-operation reset.
module tb_mult_div;
    logic        clk = 1'b0;
    logic        reset;
    logic        MULT_on, DIV_on;
    logic [31:0] A_in, B_in;
    logic [31:0] Hi_out, Lo_out;
    logic        busy, done, dzero;

    int checks = 0;
    int errors = 0;
    int lat, bcnt;

    always #5 clk = ~clk;

    mult_div #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .MULT_on (MULT_on),
        .DIV_on  (DIV_on),
        .A_in    (A_in),
        .B_in    (B_in),
        .Hi_out  (Hi_out),
        .Lo_out  (Lo_out),
        .busy    (busy),
        .done    (done),
        .dzero   (dzero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one start pulse, optionally injects a DIV_on pulse at cycle inj,
    // and returns the cycle (counted from the start edge) in which done is seen.
    task automatic run_op(input logic mul, input logic dv, input logic [31:0] a,
                          input logic [31:0] b, input int inj,
                          output int lat_o, output int bcnt_o);
        lat_o  = 99;
        bcnt_o = 0;
        @(negedge clk);
        MULT_on = mul;
        DIV_on  = dv;
        A_in    = a;
        B_in    = b;
        @(negedge clk);
        MULT_on = 1'b0;
        DIV_on  = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            DIV_on = (c == inj);
            if (c == inj) begin
                A_in = 32'd9;
                B_in = 32'd0;
            end
            if (busy) bcnt_o++;
            if (done) begin
                lat_o = c;
                break;
            end
        end
        DIV_on = 1'b0;
    endtask

    task automatic chk_idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_dzero_low"}, {31'd0, dzero}, 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        MULT_on = 1'b0;
        DIV_on  = 1'b0;
        A_in    = '0;
        B_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", Hi_out, 32'd0);
        chk("rst_lo", Lo_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dzero", {31'd0, dzero}, 32'd0);
        reset = 1'b1;

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, bcnt);
        chk("m7x-3_lat", lat, 32'd33);
        chk("m7x-3_busy_cycles", bcnt, 32'd33);
        chk("m7x-3_hi", Hi_out, 32'hFFFF_FFFF);
        chk("m7x-3_lo", Lo_out, 32'hFFFF_FFEB);
        chk("m7x-3_dzero", {31'd0, dzero}, 32'd0);
        chk_idle_after("m7x-3");

        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, bcnt);
        chk("mmin_lat", lat, 32'd33);
        chk("mmin_hi", Hi_out, 32'h4000_0000);
        chk("mmin_lo", Lo_out, 32'h0000_0000);

        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt);
        chk("d-7/2_lat", lat, 32'd34);
        chk("d-7/2_busy_cycles", bcnt, 32'd34);
        chk("d-7/2_lo", Lo_out, 32'hFFFF_FFFD);
        chk("d-7/2_hi", Hi_out, 32'hFFFF_FFFF);
        chk("d-7/2_dzero", {31'd0, dzero}, 32'd0);
        chk_idle_after("d-7/2");

        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, bcnt);
        chk("d7/-2_lo", Lo_out, 32'hFFFF_FFFD);
        chk("d7/-2_hi", Hi_out, 32'd1);

        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt);
        chk("dovf_lo", Lo_out, 32'h8000_0000);
        chk("dovf_hi", Hi_out, 32'd0);
        chk("dovf_dzero", {31'd0, dzero}, 32'd0);

        // 0x451 / 0x20 leaves Hi/Lo = 0x11/0x22 ahead of the divide by zero
        run_op(1'b0, 1'b1, 32'h451, 32'h20, 0, lat, bcnt);
        chk("dprep_lo", Lo_out, 32'h22);
        chk("dprep_hi", Hi_out, 32'h11);
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, lat, bcnt);
        chk("dz_lat", lat, 32'd1);
        chk("dz_flag", {31'd0, dzero}, 32'd1);
        chk("dz_hi_held", Hi_out, 32'h11);
        chk("dz_lo_held", Lo_out, 32'h22);
        chk_idle_after("dz");

        run_op(1'b1, 1'b0, 32'hFFFF_FC18, 32'd1000, 10, lat, bcnt);
        chk("mign_lat", lat, 32'd33);
        chk("mign_hi", Hi_out, 32'hFFFF_FFFF);
        chk("mign_lo", Lo_out, 32'hFFF0_BDC0);
        chk("mign_dzero", {31'd0, dzero}, 32'd0);
        chk_idle_after("mign");

        run_op(1'b1, 1'b1, 32'd9, 32'd3, 0, lat, bcnt);
        chk("both_lat", lat, 32'd34);
        chk("both_lo", Lo_out, 32'd3);
        chk("both_hi", Hi_out, 32'd0);

        @(negedge clk);
        DIV_on = 1'b1;
        A_in   = 32'd100;
        B_in   = 32'd7;
        @(negedge clk);
        DIV_on = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_dzero", {31'd0, dzero}, 32'd0);
        chk("abort_hi", Hi_out, 32'd0);
        chk("abort_lo", Lo_out, 32'd0);
        reset = 1'b1;

        run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, lat, bcnt);
        chk("m3x4_lat", lat, 32'd33);
        chk("m3x4_lo", Lo_out, 32'd12);
        chk("m3x4_hi", Hi_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
